// File: rtl/lock_controller_pkg.sv
// lock_controller_pkg: state encoding and key-entry defaults shared with the key-entry block
package lock_controller_pkg;
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ENTRY    = 3'd1,
    CHECK    = 3'd2,
    UNLOCKED = 3'd3,
    ERROR    = 3'd4,
    LOCKOUT  = 3'd5
  } state_e;
  localparam int DEF_KEY_WIDTH = 4;
  localparam int DEF_KEY_NUMBERS = 6;
  localparam int DEF_KEY_NUMBERS_STORE_WIDTH = 3;
endpackage

// File: rtl/lock_timer.sv
// lock_timer: shared state timer, sync clear, expires on the last cycle of a per-state limit
module lock_timer #(
  parameter int W = 32
) (
  input  logic         clock_i,
  input  logic         reset_n_i,
  input  logic         clr_i,
  input  logic [W-1:0] limit_i,
  output logic         expired_o
);
  logic [W-1:0] cnt_q;
  always_ff @(posedge clock_i or negedge reset_n_i)
    if (!reset_n_i) cnt_q <= '0;
    else cnt_q <= clr_i ? '0 : cnt_q + 1'b1;
  assign expired_o = cnt_q == limit_i - 1'b1;
endmodule

// File: rtl/lock_controller.sv
// lock_controller: password check FSM with attempt counting, lockout and auto-relock
module lock_controller
  import lock_controller_pkg::*;
#(
  parameter int KEY_WIDTH = DEF_KEY_WIDTH,
  parameter int KEY_NUMBERS = DEF_KEY_NUMBERS,
  parameter int KEY_NUMBERS_STORE_WIDTH = DEF_KEY_NUMBERS_STORE_WIDTH,
  parameter logic [KEY_WIDTH*KEY_NUMBERS-1:0] PASSWORD = 24'h123456,
  parameter int MAX_ATTEMPTS = 3,
  parameter int ATTEMPT_WIDTH = 2,
  parameter int ENTRY_TIMEOUTS = 5,
  parameter int TIMER_WIDTH = 32,
  parameter int UNLOCK_CYCLES = 250_000_000,
  parameter int ERROR_CYCLES = 50_000_000,
  parameter int LOCKOUT_CYCLES = 1_500_000_000
) (
  input  logic                               clock,
  input  logic                               reset_n,
  input  logic [KEY_WIDTH*KEY_NUMBERS-1:0]   keyValueStore,
  input  logic [KEY_NUMBERS_STORE_WIDTH-1:0] keyNumbersStore,
  input  logic                               timeValueFlag,
  input  logic                               relockRequest,
  output logic                               keyInputClear,
  output logic                               unlockState,
  output logic                               errorFlag,
  output logic                               lockoutState,
  output logic [ATTEMPT_WIDTH-1:0]           attemptCount,
  output logic [2:0]                         lockState
);
  localparam int KW = KEY_WIDTH * KEY_NUMBERS;
  localparam int TW = $clog2(ENTRY_TIMEOUTS + 1);
  state_e state_q, state_d;
  logic [KW-1:0] key_q, cap_q, cap_d;
  logic [KEY_NUMBERS_STORE_WIDTH-1:0] cnt_q;
  logic tflag_q, relock_q, clr_q, clr_d, expired;
  logic [ATTEMPT_WIDTH-1:0] att_q, att_d;
  logic [TW-1:0] to_q, to_d;
  logic [TIMER_WIDTH-1:0] limit;
  assign limit = state_q == UNLOCKED ? TIMER_WIDTH'(UNLOCK_CYCLES)
               : state_q == ERROR    ? TIMER_WIDTH'(ERROR_CYCLES)
               :                       TIMER_WIDTH'(LOCKOUT_CYCLES);
  lock_timer #(.W(TIMER_WIDTH)) u_timer (
    .clock_i   (clock),
    .reset_n_i (reset_n),
    .clr_i     (state_d != state_q),
    .limit_i   (limit),
    .expired_o (expired)
  );
  always_comb begin
    state_d = state_q;
    att_d = att_q;
    to_d = to_q;
    cap_d = cap_q;
    clr_d = 1'b0;
    case (state_q)
      IDLE: begin
        to_d = '0;
        if (cnt_q != '0) state_d = ENTRY;
      end
      ENTRY: begin
        if (cnt_q == KEY_NUMBERS_STORE_WIDTH'(KEY_NUMBERS)) begin
          state_d = CHECK;
          cap_d = key_q;
        end else if (cnt_q == '0) begin
          state_d = IDLE;
        end else if (tflag_q) begin
          to_d = to_q + 1'b1;
          if (to_d == TW'(ENTRY_TIMEOUTS)) begin
            state_d = IDLE;
            clr_d = 1'b1;
          end
        end
      end
      CHECK: begin
        clr_d = 1'b1;
        if (cap_q == PASSWORD) begin
          state_d = UNLOCKED;
          att_d = '0;
        end else begin
          att_d = att_q == ATTEMPT_WIDTH'(MAX_ATTEMPTS) ? att_q : att_q + 1'b1;
          state_d = att_d == ATTEMPT_WIDTH'(MAX_ATTEMPTS) ? LOCKOUT : ERROR;
        end
      end
      UNLOCKED: begin
        if (relock_q || expired) begin
          state_d = IDLE;
          clr_d = 1'b1;
        end
      end
      ERROR: state_d = expired ? IDLE : ERROR;
      LOCKOUT: begin
        if (expired) begin
          state_d = IDLE;
          att_d = '0;
        end else begin
          // keys typed during lockout are discarded; spacing keeps the edge-triggered consumer happy
          clr_d = cnt_q != '0 && !clr_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      key_q <= '0;
      cnt_q <= '0;
      tflag_q <= 1'b0;
      relock_q <= 1'b0;
      cap_q <= '0;
      att_q <= '0;
      to_q <= '0;
      clr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q <= keyValueStore;
      cnt_q <= keyNumbersStore;
      tflag_q <= timeValueFlag;
      relock_q <= relockRequest;
      cap_q <= cap_d;
      att_q <= att_d;
      to_q <= to_d;
      clr_q <= clr_d;
    end
  end
  assign keyInputClear = clr_q;
  assign unlockState = state_q == UNLOCKED;
  assign errorFlag = state_q == ERROR;
  assign lockoutState = state_q == LOCKOUT;
  assign attemptCount = att_q;
  assign lockState = state_q;
endmodule

// File: tb/tb_lock_controller.sv
// tb_lock_controller: scenario tasks with a scoreboard of expected CHECK outcomes
module tb_lock_controller;
  import lock_controller_pkg::*;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [23:0] kv = '0;
  logic [2:0] kn = '0;
  logic tf = 1'b0, rr = 1'b0;
  logic clr, unl, err, lko;
  logic [1:0] att;
  logic [2:0] st;
  int passed = 0, total = 0;
  typedef struct packed {logic [2:0] st; logic [1:0] att;} exp_t;
  exp_t sbq[$];
  always #5 clk = ~clk;
  lock_controller #(
    .ENTRY_TIMEOUTS(2), .UNLOCK_CYCLES(20), .ERROR_CYCLES(10), .LOCKOUT_CYCLES(40)
  ) dut (
    .clock(clk), .reset_n(rst_n), .keyValueStore(kv), .keyNumbersStore(kn),
    .timeValueFlag(tf), .relockRequest(rr), .keyInputClear(clr), .unlockState(unl),
    .errorFlag(err), .lockoutState(lko), .attemptCount(att), .lockState(st)
  );
  task automatic tick();
    @(negedge clk);
  endtask
  function automatic logic sel(input int which);
    return which == 0 ? unl : which == 1 ? err : lko;
  endfunction
  task automatic measure(input int which, output int n, output int pulses);
    n = 0;
    pulses = 0;
    while (n < 200 && sel(which)) begin
      n++;
      tick();
      if (clr && sel(which)) pulses++;
    end
  endtask
  task automatic submit(input logic [23:0] code, input logic [2:0] est, input logic [1:0] eatt);
    int lat;
    exp_t e;
    sbq.push_back('{est, eatt});
    for (int i = 1; i <= 6; i++) begin
      kn = 3'(i);
      kv = code >> (4 * (6 - i));
      tick();
    end
    lat = 1;
    while (!clr && lat < 12) begin
      tick();
      lat++;
    end
    kn = '0;
    kv = '0;
    e = sbq.pop_front();
    total++; if (clr !== 1'b1) $display("FAIL submit_clear: got %0b exp 1", clr); else passed++;
    total++; if (st !== e.st) $display("FAIL submit_state: got %0d exp %0d", st, e.st); else passed++;
    total++; if (att !== e.att) $display("FAIL submit_attempts: got %0d exp %0d", att, e.att); else passed++;
    total++; if (lat !== 3) $display("FAIL submit_latency: got %0d exp 3", lat); else passed++;
  endtask
  task automatic test_reset();
    tick();
    total++; if ({clr, unl, err, lko, att, st} !== '0) $display("FAIL reset_outputs: got %0h exp 0", {clr, unl, err, lko, att, st}); else passed++;
    rst_n = 1'b1;
    tick();
    tick();
    total++; if (st !== IDLE || clr !== 1'b0) $display("FAIL reset_idle: got st=%0d clr=%0b exp st=0 clr=0", st, clr); else passed++;
  endtask
  task automatic test_unlock();
    int n, p;
    submit(24'h123456, UNLOCKED, 2'd0);
    total++; if (unl !== 1'b1) $display("FAIL unlock_high: got %0b exp 1", unl); else passed++;
    measure(0, n, p);
    total++; if (n !== 20) $display("FAIL unlock_cycles: got %0d exp 20", n); else passed++;
    total++; if (p !== 0) $display("FAIL unlock_extra_clears: got %0d exp 0", p); else passed++;
    total++; if (clr !== 1'b1) $display("FAIL unlock_expiry_clear: got %0b exp 1", clr); else passed++;
    tick();
    total++; if (clr !== 1'b0 || st !== IDLE) $display("FAIL unlock_exit: got clr=%0b st=%0d exp clr=0 st=0", clr, st); else passed++;
  endtask
  task automatic test_lockout();
    int n, p;
    for (int k = 1; k <= 2; k++) begin
      submit(24'h123450, ERROR, 2'(k));
      total++; if (err !== 1'b1) $display("FAIL error_high: got %0b exp 1", err); else passed++;
      measure(1, n, p);
      total++; if (n !== 10) $display("FAIL error_cycles: got %0d exp 10", n); else passed++;
      total++; if (st !== IDLE || clr !== 1'b0) $display("FAIL error_exit: got st=%0d clr=%0b exp st=0 clr=0", st, clr); else passed++;
    end
    submit(24'h123450, LOCKOUT, 2'd3);
    measure(2, n, p);
    total++; if (n !== 40) $display("FAIL lockout_cycles: got %0d exp 40", n); else passed++;
    total++; if (p !== 0) $display("FAIL lockout_idle_clears: got %0d exp 0", p); else passed++;
    total++; if (att !== 2'd0 || st !== IDLE) $display("FAIL lockout_exit: got att=%0d st=%0d exp att=0 st=0", att, st); else passed++;
  endtask
  task automatic test_relock();
    int n, p, w;
    submit(24'h654321, ERROR, 2'd1);
    measure(1, n, p);
    submit(24'h000000, ERROR, 2'd2);
    measure(1, n, p);
    submit(24'h123456, UNLOCKED, 2'd0);
    repeat (4) tick();
    rr = 1'b1;
    tick();
    rr = 1'b0;
    w = 1;
    while (!clr && w < 6) begin
      tick();
      w++;
    end
    total++; if (clr !== 1'b1 || w !== 2) $display("FAIL relock_clear: got clr=%0b wait=%0d exp clr=1 wait=2", clr, w); else passed++;
    total++; if (st !== IDLE || unl !== 1'b0) $display("FAIL relock_state: got st=%0d unl=%0b exp st=0 unl=0", st, unl); else passed++;
    tick();
    total++; if (clr !== 1'b0) $display("FAIL relock_single_pulse: got %0b exp 0", clr); else passed++;
  endtask
  task automatic test_entry_timeout();
    int n, p, w;
    submit(24'hABCDEF, ERROR, 2'd1);
    measure(1, n, p);
    for (int i = 1; i <= 3; i++) begin
      kn = 3'(i);
      kv = 24'h000123 >> (4 * (3 - i));
      tick();
    end
    tick();
    total++; if (st !== ENTRY) $display("FAIL timeout_entry: got %0d exp 1", st); else passed++;
    tf = 1'b1;
    tick();
    tf = 1'b0;
    tick();
    tick();
    total++; if (clr !== 1'b0 || st !== ENTRY) $display("FAIL timeout_first: got clr=%0b st=%0d exp clr=0 st=1", clr, st); else passed++;
    tf = 1'b1;
    tick();
    tf = 1'b0;
    w = 1;
    while (!clr && w < 6) begin
      tick();
      w++;
    end
    kn = '0;
    kv = '0;
    total++; if (clr !== 1'b1) $display("FAIL timeout_clear: got %0b exp 1", clr); else passed++;
    total++; if (st !== IDLE || att !== 2'd1) $display("FAIL timeout_abort: got st=%0d att=%0d exp st=0 att=1", st, att); else passed++;
    repeat (3) tick();
    total++; if (st !== IDLE || att !== 2'd1) $display("FAIL timeout_settle: got st=%0d att=%0d exp st=0 att=1", st, att); else passed++;
  endtask
  task automatic test_lockout_keys();
    int n, p, pulses, consec;
    logic prev;
    submit(24'h111111, ERROR, 2'd2);
    measure(1, n, p);
    submit(24'h222222, LOCKOUT, 2'd3);
    repeat (3) tick();
    kn = 3'd1;
    kv = 24'h7;
    prev = 1'b0;
    pulses = 0;
    consec = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i == 4) begin
        kn = 3'd2;
        kv = 24'h78;
      end
      if (clr && prev) consec++;
      if (clr) pulses++;
      prev = clr;
    end
    kn = '0;
    kv = '0;
    total++; if (consec !== 0) $display("FAIL lockout_keys_consecutive: got %0d exp 0", consec); else passed++;
    total++; if (pulses < 2) $display("FAIL lockout_keys_pulses: got %0d exp >=2", pulses); else passed++;
    total++; if (lko !== 1'b1 || rr !== 1'b0) $display("FAIL lockout_keys_held: got %0b exp 1", lko); else passed++;
    measure(2, n, p);
    total++; if (att !== 2'd0 || st !== IDLE) $display("FAIL lockout_keys_exit: got att=%0d st=%0d exp att=0 st=0", att, st); else passed++;
  endtask
  task automatic test_reset_mid();
    int n, p, cp;
    submit(24'h123456, UNLOCKED, 2'd0);
    repeat (3) tick();
    #2 rst_n = 1'b0;
    #1;
    total++; if ({clr, unl, err, lko, att, st} !== '0) $display("FAIL reset_mid_unlock: got %0h exp 0", {clr, unl, err, lko, att, st}); else passed++;
    tick();
    rst_n = 1'b1;
    cp = 0;
    repeat (3) begin
      tick();
      if (clr) cp++;
    end
    total++; if (cp !== 0 || st !== IDLE) $display("FAIL reset_mid_noclear: got clears=%0d st=%0d exp 0 0", cp, st); else passed++;
    submit(24'h000001, ERROR, 2'd1);
    measure(1, n, p);
    submit(24'h000002, ERROR, 2'd2);
    measure(1, n, p);
    submit(24'h000003, LOCKOUT, 2'd3);
    repeat (5) tick();
    #2 rst_n = 1'b0;
    #1;
    total++; if ({clr, unl, err, lko, att, st} !== '0) $display("FAIL reset_mid_lockout: got %0h exp 0", {clr, unl, err, lko, att, st}); else passed++;
    tick();
    rst_n = 1'b1;
    cp = 0;
    repeat (3) begin
      tick();
      if (clr) cp++;
    end
    total++; if (cp !== 0 || st !== IDLE || att !== 2'd0) $display("FAIL reset_mid_recover: got clears=%0d st=%0d att=%0d exp 0 0 0", cp, st, att); else passed++;
  endtask
  initial begin
    test_reset();
    test_unlock();
    test_lockout();
    test_relock();
    test_entry_timeout();
    test_lockout_keys();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout exp completion");
    $fatal(1, "watchdog expired");
  end
endmodule
